converter_scheduler: RTL

- Round-robin scheduler that shares one power_converter → data_collector path among NUM_SRC renewable sources (solar, wind, hydro, battery).
- Grants one source, latches its raw sample, and sequences it through the converter with a start/done handshake and a conversion timeout.
- Presents the converted result to the data collector with a valid/ready handshake.
- Sits between the source front-ends and the converter/collector pair, inside the top-level wrapper.

---
 rtl/converter_sched_pkg.sv | 20 ++
 rtl/converter_scheduler_rr_arbiter.sv | 33 +++
 rtl/converter_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/converter_sched_pkg.sv
// Shared state type, default sizes and index-width helper for the converter
// scheduler and its round-robin arbiter.
package converter_sched_pkg;

  localparam int DEF_NUM_SRC      = 4;
  localparam int DEF_W            = 8;
  localparam int DEF_CONV_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOG     = 2'd2
  } sched_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/converter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: lowest eligible index at or after
// last_grant+1 (mod N), returned one-hot and as an index.
module rr_arbiter
  import converter_sched_pkg::*;
#(
  parameter int N = DEF_NUM_SRC,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_grant) + k) % N);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/converter_scheduler.sv
// Round-robin scheduler sharing one converter -> collector path among sources.
// Optional over-voltage trip: define CONVERTER_SCHEDULER_OVERVOLT_TRIP_EN.
//
// state      | meaning
// ST_IDLE    | waiting for an eligible request (one idle cycle after each log)
// ST_CONVERT | sample handed to converter, waiting for done or timeout
// ST_LOG     | result offered to collector until log_ready
module converter_scheduler
  import converter_sched_pkg::*;
#(
  parameter int           NUM_SRC      = DEF_NUM_SRC,
  parameter int           W            = DEF_W,
  parameter int           CONV_TIMEOUT = DEF_CONV_TIMEOUT,
  parameter logic [W-1:0] TRIP_LEVEL   = W'(8'hF0),
  localparam int          IW           = idx_width(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC*W-1:0] src_data,
  output logic [NUM_SRC-1:0]   src_ack,
  output logic [W-1:0]         conv_in,
  output logic                 conv_start,
  input  logic                 conv_done,
  input  logic [W-1:0]         conv_result,
  output logic                 log_valid,
  output logic [W-1:0]         log_data,
  output logic [IW-1:0]        log_src,
  input  logic                 log_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [NUM_SRC-1:0]   trip_flags
);

  localparam int            TW         = idx_width(CONV_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CONV_TIMEOUT - 1);

  sched_state_t state, state_nxt;
  logic [IW-1:0] last_grant, last_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          hold, hold_nxt;

  logic [NUM_SRC-1:0] ack_nxt;
  logic               start_nxt;
  logic [W-1:0]       conv_in_nxt;
  logic               valid_nxt;
  logic [W-1:0]       data_nxt;
  logic [IW-1:0]      src_nxt;
  logic               tmo_nxt;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic [W-1:0]       src_sample [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_sample[i] = src_data[i*W +: W];
    end
  end

`ifdef CONVERTER_SCHEDULER_OVERVOLT_TRIP_EN
  // Flags are sticky until reset; the tripping result is still logged.
  always_ff @(posedge clk) begin
    if (rst) begin
      trip_flags <= '0;
    end else if (state == ST_CONVERT && conv_done && conv_result > TRIP_LEVEL) begin
      trip_flags[log_src] <= 1'b1;
    end
  end

  assign eligible = src_req & ~trip_flags;
`else
  assign trip_flags = '0;
  assign eligible   = src_req;
`endif

  rr_arbiter #(
    .N(NUM_SRC)
  ) u_arb (
    .eligible  (eligible),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_nxt   = state;
    last_nxt    = last_grant;
    timer_nxt   = timer;
    hold_nxt    = 1'b0;
    ack_nxt     = '0;
    start_nxt   = 1'b0;
    conv_in_nxt = conv_in;
    valid_nxt   = log_valid;
    data_nxt    = log_data;
    src_nxt     = log_src;
    tmo_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        // hold marks the cooldown cycle right after a log transfer
        if (!hold && (|grant)) begin
          ack_nxt     = grant;
          start_nxt   = 1'b1;
          conv_in_nxt = src_sample[grant_idx];
          src_nxt     = grant_idx;
          last_nxt    = grant_idx;
          timer_nxt   = '0;
          state_nxt   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // done has priority over the expiry cycle
        if (conv_done) begin
          data_nxt  = conv_result;
          valid_nxt = 1'b1;
          state_nxt = ST_LOG;
        end else if (timer == TIMER_LAST) begin
          tmo_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_LOG: begin
        if (log_ready) begin
          valid_nxt = 1'b0;
          hold_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= IW'(NUM_SRC - 1);
      timer       <= '0;
      hold        <= 1'b0;
      src_ack     <= '0;
      conv_start  <= 1'b0;
      conv_in     <= '0;
      log_valid   <= 1'b0;
      log_data    <= '0;
      log_src     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_nxt;
      timer       <= timer_nxt;
      hold        <= hold_nxt;
      src_ack     <= ack_nxt;
      conv_start  <= start_nxt;
      conv_in     <= conv_in_nxt;
      log_valid   <= valid_nxt;
      log_data    <= data_nxt;
      log_src     <= src_nxt;
      timeout_err <= tmo_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
